multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the RV32I-subset datapath. It sequences IF/ID/EX/MEM/WB and drives every datapath control: PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC. It also drives the data-memory strobes MemRead/MemWrite.
Compared with the fixed 5-cycle controller it adds:
- a memory ready handshake;
- optional MEM-state skipping;
- BNE support;
- illegal-instruction detection;
- a retire pulse.

---
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB control unit for the RV32I-subset datapath.
// Adds a memory-ready handshake, optional MEM skipping, BNE, illegal detection and a retire pulse.
module multicycle_ctrl #(
  parameter bit SKIP_MEM      = 1'b1,
  parameter bit SUPPORT_BNE   = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal_instr,
  output logic        instr_retired,
  output logic [2:0]  fsm_state
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSrl = 4'b1000;
  localparam logic [3:0] AluSll = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1010;
  localparam logic [3:0] AluXor = 4'b1101;

  typedef enum logic [2:0] {
    StIf  = 3'b000,
    StId  = 3'b001,
    StEx  = 3'b010,
    StMem = 3'b011,
    StWb  = 3'b100
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_mem, legal;
  logic       unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign is_r   = (opcode == OpR);
  assign is_i   = (opcode == OpI);
  assign is_lw  = (opcode == OpLoad)   && (funct3 == 3'b010);
  assign is_sw  = (opcode == OpStore)  && (funct3 == 3'b010);
  assign is_beq = (opcode == OpBranch) && (funct3 == 3'b000);
  assign is_bne = SUPPORT_BNE && (opcode == OpBranch) && (funct3 == 3'b001);
  assign is_mem = is_lw || is_sw;
  assign legal  = is_r || is_i || is_lw || is_sw || is_beq || is_bne;

  // Register indices and immediates are the datapath's business, not ours.
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      3'b111:  op = AluAnd;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

  always_comb begin
    ALUCtrl = AluAdd;
    if (is_r) begin
      ALUCtrl = alu_op(funct3, instr[30]);
    end else if (is_i) begin
      // addi has no subtract form; instr[30] is immediate data there
      ALUCtrl = (funct3 == 3'b000) ? AluAdd : alu_op(funct3, instr[30]);
    end else if (is_beq || is_bne) begin
      ALUCtrl = AluSub;
    end
  end

  assign ALUSrc   = is_i || is_lw || is_sw;
  assign MemToReg = is_lw;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIf: state_d = StId;
      StId: state_d = StEx;
      StEx: state_d = (is_mem || !SKIP_MEM) ? StMem : StWb;
      StMem: begin
        if (!MEM_HANDSHAKE || mem_ready) begin
          state_d = StWb;
        end
      end
      StWb:    state_d = StIf;
      default: state_d = StIf;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    PCSrc         = 1'b0;
    RegWrite      = 1'b0;
    loadPC        = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      StMem: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      StWb: begin
        loadPC        = 1'b1;
        RegWrite      = is_r || is_i || is_lw;
        PCSrc         = (is_beq && Zero) || (is_bne && !Zero);
        instr_retired = 1'b1;
      end
      default: ;
    endcase
  end

  // Sticky illegal flag, latched as the offending instruction retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if ((state_q == StWb) && !legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_instr = illegal_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: default build (a) and SKIP_MEM=0/SUPPORT_BNE=0/
// MEM_HANDSHAKE=0 build (b) share stimulus; each task checks the build it targets.
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_SRA = 32'h4020D1B3;
  localparam logic [31:0] I_LW  = 32'h0000A183;
  localparam logic [31:0] I_LB  = 32'h00008183;
  localparam logic [31:0] I_SW  = 32'h0020A023;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BNE = 32'h00209463;

  // {fsm_state, PCSrc, RegWrite, loadPC, MemRead, MemWrite, instr_retired}
  localparam logic [8:0] XIF  = 9'b000_000000;
  localparam logic [8:0] XID  = 9'b001_000000;
  localparam logic [8:0] XEX  = 9'b010_000000;
  localparam logic [8:0] XMEM = 9'b011_000000;
  localparam logic [8:0] XMRD = 9'b011_000100;
  localparam logic [8:0] XMWR = 9'b011_000010;
  localparam logic [8:0] XWBR = 9'b100_011001;
  localparam logic [8:0] XWBN = 9'b100_001001;
  localparam logic [8:0] XWBB = 9'b100_101001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = I_ADD;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic       pcsrc_a, alusrc_a, regwrite_a, memtoreg_a, loadpc_a, memread_a, memwrite_a;
  logic       illegal_a, retired_a;
  logic [3:0] aluctrl_a;
  logic [2:0] state_a;
  logic       pcsrc_b, alusrc_b, regwrite_b, memtoreg_b, loadpc_b, memread_b, memwrite_b;
  logic       illegal_b, retired_b;
  logic [3:0] aluctrl_b;
  logic [2:0] state_b;
  logic [8:0] obs_a, obs_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign obs_a = {state_a, pcsrc_a, regwrite_a, loadpc_a, memread_a, memwrite_a, retired_a};
  assign obs_b = {state_b, pcsrc_b, regwrite_b, loadpc_b, memread_b, memwrite_b, retired_b};

  multicycle_ctrl dut_a (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .Zero          (Zero),
    .mem_ready     (mem_ready),
    .PCSrc         (pcsrc_a),
    .ALUSrc        (alusrc_a),
    .RegWrite      (regwrite_a),
    .MemToReg      (memtoreg_a),
    .ALUCtrl       (aluctrl_a),
    .loadPC        (loadpc_a),
    .MemRead       (memread_a),
    .MemWrite      (memwrite_a),
    .illegal_instr (illegal_a),
    .instr_retired (retired_a),
    .fsm_state     (state_a)
  );

  multicycle_ctrl #(
    .SKIP_MEM      (1'b0),
    .SUPPORT_BNE   (1'b0),
    .MEM_HANDSHAKE (1'b0)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .Zero          (Zero),
    .mem_ready     (mem_ready),
    .PCSrc         (pcsrc_b),
    .ALUSrc        (alusrc_b),
    .RegWrite      (regwrite_b),
    .MemToReg      (memtoreg_b),
    .ALUCtrl       (aluctrl_b),
    .loadPC        (loadpc_b),
    .MemRead       (memread_b),
    .MemWrite      (memwrite_b),
    .illegal_instr (illegal_b),
    .instr_retired (retired_b),
    .fsm_state     (state_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs in the first IF cycle.
  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_a !== XIF || illegal_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: obs=%b ill=%b exp=%b ill=0", obs_a, illegal_a, XIF);
    end
    n_checks++;
    if (obs_b !== XIF || illegal_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: obs=%b ill=%b exp=%b ill=0", obs_b, illegal_b, XIF);
    end
  endtask

  task automatic test_alu_decode();
    logic [31:0] ins [12];
    logic [5:0]  exp [12]; // {ALUSrc, MemToReg, ALUCtrl}
    ins = '{32'h0020A1B3, 32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3, 32'h002091B3, 32'h0020D1B3,
            32'h40008193, 32'h0000C193, 32'h4000D193, I_LW, I_BEQ, 32'h00000000};
    exp = '{6'b00_0111, 6'b00_1101, 6'b00_0001, 6'b00_0000, 6'b00_1001, 6'b00_1000,
            6'b10_0010, 6'b10_1101, 6'b10_1010, 6'b11_0010, 6'b00_0110, 6'b00_0010};
    for (int k = 0; k < 12; k++) begin
      instr = ins[k];
      #1;
      n_checks++;
      if ({alusrc_a, memtoreg_a, aluctrl_a} !== exp[k]) begin
        n_fail++;
        $display("FAIL decode[%0d] %h: got=%b exp=%b", k, ins[k],
                 {alusrc_a, memtoreg_a, aluctrl_a}, exp[k]);
      end
    end
  endtask

  task automatic test_add();
    logic [8:0] ex [5];
    ex = '{XIF, XID, XEX, XWBR, XIF};
    instr = I_ADD;
    Zero = 1'b0;
    mem_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      n_checks++;
      if (obs_a !== ex[c] || aluctrl_a !== 4'b0010) begin
        n_fail++;
        $display("FAIL add c%0d: obs=%b alu=%b exp=%b alu=0010", c, obs_a, aluctrl_a, ex[c]);
      end
    end
  endtask

  task automatic test_lw_handshake();
    logic [8:0] ex [9];
    ex = '{XIF, XID, XEX, XMRD, XMRD, XMRD, XMRD, XWBR, XIF};
    instr = I_LW;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) cyc();
      mem_ready = (c < 3) || (c == 6); // high before MEM must be ignored
      n_checks++;
      if (obs_a !== ex[c]) begin
        n_fail++;
        $display("FAIL lw c%0d: obs=%b exp=%b", c, obs_a, ex[c]);
      end
      if (c == 7) begin
        n_checks++;
        if (memtoreg_a !== 1'b1) begin
          n_fail++;
          $display("FAIL lw_memtoreg: got=%b exp=1", memtoreg_a);
        end
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_beq();
    logic [8:0] ex [5];
    for (int k = 0; k < 2; k++) begin
      Zero = (k == 0);
      ex = '{XIF, XID, XEX, (k == 0) ? XWBB : XWBN, XIF};
      instr = I_BEQ;
      do_reset();
      for (int c = 0; c < 5; c++) begin
        if (c > 0) cyc();
        n_checks++;
        if (obs_a !== ex[c] || aluctrl_a !== 4'b0110) begin
          n_fail++;
          $display("FAIL beq z%0d c%0d: obs=%b alu=%b exp=%b alu=0110", 1 - k, c, obs_a,
                   aluctrl_a, ex[c]);
        end
      end
    end
  endtask

  task automatic test_bne();
    logic [8:0] ex_a [7];
    logic [8:0] ex_b [7];
    ex_a = '{XIF, XID, XEX, XWBB, XIF, XID, XEX};
    ex_b = '{XIF, XID, XEX, XMEM, XWBN, XIF, XID};
    instr = I_BNE;
    Zero = 1'b0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) cyc();
      n_checks++;
      if (obs_a !== ex_a[c] || illegal_a !== 1'b0 || aluctrl_a !== 4'b0110) begin
        n_fail++;
        $display("FAIL bne_a c%0d: obs=%b ill=%b alu=%b exp=%b ill=0 alu=0110", c, obs_a,
                 illegal_a, aluctrl_a, ex_a[c]);
      end
      n_checks++;
      if (obs_b !== ex_b[c] || aluctrl_b !== 4'b0010) begin
        n_fail++;
        $display("FAIL bne_b c%0d: obs=%b alu=%b exp=%b alu=0010", c, obs_b, aluctrl_b, ex_b[c]);
      end
      if (c != 4) begin
        n_checks++;
        if (illegal_b !== (c > 4)) begin
          n_fail++;
          $display("FAIL bne_b_illegal c%0d: got=%b exp=%b", c, illegal_b, (c > 4));
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [8:0] ex [5];
    ex = '{XIF, XID, XEX, XWBN, XIF};
    instr = I_LB;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      n_checks++;
      if (obs_a !== ex[c]) begin
        n_fail++;
        $display("FAIL lb c%0d: obs=%b exp=%b", c, obs_a, ex[c]);
      end
      if (c != 3) begin
        n_checks++;
        if (illegal_a !== (c == 4)) begin
          n_fail++;
          $display("FAIL lb_illegal c%0d: got=%b exp=%b", c, illegal_a, (c == 4));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ex [11];
    ex = '{XIF, XID, XEX, XMEM, XWBR, XIF, XID, XEX, XMEM, XWBR, XIF};
    instr = I_SUB;
    mem_ready = 1'b0; // handshake disabled in build b
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) cyc();
      instr = (c < 5) ? I_SUB : I_SRA;
      #1;
      n_checks++;
      if (obs_b !== ex[c]) begin
        n_fail++;
        $display("FAIL b2b c%0d: obs=%b exp=%b", c, obs_b, ex[c]);
      end
      if (c == 2 || c == 7) begin
        n_checks++;
        if (aluctrl_b !== ((c == 2) ? 4'b0110 : 4'b1010)) begin
          n_fail++;
          $display("FAIL b2b_alu c%0d: got=%b exp=%b", c, aluctrl_b,
                   (c == 2) ? 4'b0110 : 4'b1010);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    logic [8:0] ex [5];
    ex = '{XIF, XID, XEX, XMWR, XMWR};
    instr = I_SW;
    mem_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      n_checks++;
      if (obs_a !== ex[c]) begin
        n_fail++;
        $display("FAIL sw c%0d: obs=%b exp=%b", c, obs_a, ex[c]);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_a !== XIF || illegal_a !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_async_rst: obs=%b ill=%b exp=%b ill=0", obs_a, illegal_a, XIF);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_checks++;
      if (obs_a !== XIF) begin
        n_fail++;
        $display("FAIL sw_in_rst %0d: obs=%b exp=%b", k, obs_a, XIF);
      end
    end
    mem_ready = 1'b0;
    rst = 1'b0;
    cyc();
    n_checks++;
    if (obs_a !== XID) begin
      n_fail++;
      $display("FAIL sw_refetch: obs=%b exp=%b", obs_a, XID);
    end
  endtask

  initial begin
    test_reset();
    test_alu_decode();
    test_add();
    test_lw_handshake();
    test_beq();
    test_bne();
    test_illegal();
    test_back_to_back();
    test_sw_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
